// File: rtl/rrv64_l1d_stb_q_pkg.sv
// Shared constants and the store-buffer entry type for the L1D store buffer.
//   RRV64_L1D_STB_D      default entry count (power of 2, >= 2)
//   RRV64_PHY_ADDR_WIDTH physical address width
//   RRV64_L1D_STB_DATA_W entry data width (one doubleword lane)
//   RRV64_L1D_STB_IDX_W  head/tail pointer width
//   rrv64_l1d_stb_ent_t  {valid, dw_addr, data, mask} at the default widths
package rrv64_l1d_stb_q_pkg;
  localparam int RRV64_L1D_STB_D      = 16;
  localparam int RRV64_PHY_ADDR_WIDTH = 56;
  localparam int RRV64_L1D_STB_DATA_W = 64;
  localparam int RRV64_L1D_STB_IDX_W  = $clog2(RRV64_L1D_STB_D);
  localparam int RRV64_L1D_STB_MASK_W = RRV64_L1D_STB_DATA_W / 8;
  localparam int RRV64_L1D_STB_OFF_W  = $clog2(RRV64_L1D_STB_MASK_W);

  typedef struct packed {
    logic                                                valid;
    logic [RRV64_PHY_ADDR_WIDTH-1:RRV64_L1D_STB_OFF_W] dw_addr;
    logic [RRV64_L1D_STB_DATA_W-1:0]                   data;
    logic [RRV64_L1D_STB_MASK_W-1:0]                   mask;
  } rrv64_l1d_stb_ent_t;
endpackage

// File: rtl/rrv64_l1d_stb_q_if.sv
// Bus bundle of the L1D store buffer: store request in, cache write out,
// load forwarding lookup.
//   slave  : the store buffer side
//   master : LSU / L1D / load pipe side (the environment)
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. The sender holds valid and payload stable until that edge; ready may
// depend combinationally on the payload but never on valid.
interface rrv64_l1d_stb_q_if
  import rrv64_l1d_stb_q_pkg::*;
#(
  parameter int PADDR_W = RRV64_PHY_ADDR_WIDTH,
  parameter int DATA_W  = RRV64_L1D_STB_DATA_W
);
  logic                  st_req_valid;
  logic                  st_req_ready;
  logic [PADDR_W-1:0]    st_req_addr;
  logic [DATA_W-1:0]     st_req_data;
  logic [DATA_W/8-1:0]   st_req_mask;
  logic                  dc_req_valid;
  logic                  dc_req_ready;
  logic [PADDR_W-1:0]    dc_req_addr;
  logic [DATA_W-1:0]     dc_req_data;
  logic [DATA_W/8-1:0]   dc_req_mask;
  logic [PADDR_W-1:0]    ld_fwd_addr;
  logic [DATA_W-1:0]     ld_fwd_data;
  logic [DATA_W/8-1:0]   ld_fwd_mask;

  modport slave (
    input  st_req_valid, st_req_addr, st_req_data, st_req_mask,
    input  dc_req_ready, ld_fwd_addr,
    output st_req_ready, dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask,
    output ld_fwd_data, ld_fwd_mask
  );

  modport master (
    output st_req_valid, st_req_addr, st_req_data, st_req_mask,
    output dc_req_ready, ld_fwd_addr,
    input  st_req_ready, dc_req_valid, dc_req_addr, dc_req_data, dc_req_mask,
    input  ld_fwd_data, ld_fwd_mask
  );
endinterface

// File: rtl/rrv64_l1d_stb_fwd_sel.sv
// Per-byte youngest-match forwarding select over a circular entry array.
// Entries are scanned oldest -> youngest starting at i_head; a later matching
// entry overwrites an earlier one, so each byte comes from the youngest valid
// entry whose dw address matches and whose mask bit is set.
//   i_vld/i_addr/i_data/i_mask  entry state, indexed by physical slot
//   i_head                      slot of the oldest entry
//   i_lkup_addr                 dw address being looked up
//   o_data/o_mask               forwarded bytes (0 where o_mask=0)
module rrv64_l1d_stb_fwd_sel
  import rrv64_l1d_stb_q_pkg::*;
#(
  parameter int DEPTH  = RRV64_L1D_STB_D,
  parameter int AW     = RRV64_PHY_ADDR_WIDTH - RRV64_L1D_STB_OFF_W,
  parameter int DATA_W = RRV64_L1D_STB_DATA_W
)(
  input  logic [DEPTH-1:0]                 i_vld,
  input  logic [DEPTH-1:0][AW-1:0]         i_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]     i_data,
  input  logic [DEPTH-1:0][DATA_W/8-1:0]   i_mask,
  input  logic [$clog2(DEPTH)-1:0]         i_head,
  input  logic [AW-1:0]                    i_lkup_addr,
  output logic [DATA_W-1:0]                o_data,
  output logic [DATA_W/8-1:0]              o_mask
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int MASK_W = DATA_W / 8;

  always_comb begin
    logic [IDX_W-1:0] idx;
    o_data = '0;
    o_mask = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_head + IDX_W'(k);
      if (i_vld[idx] && (i_addr[idx] == i_lkup_addr)) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (i_mask[idx][b]) begin
            o_mask[b]        = 1'b1;
            o_data[b*8 +: 8] = i_data[idx][b*8 +: 8];
          end
        end
      end
    end
  end
endmodule

// File: rtl/rrv64_l1d_stb_q.sv
// L1D store buffer: holds committed stores in program order, drains them FIFO
// to the L1D write port and forwards bytes to younger loads.
// Optional write coalescing: define RRV64_L1D_STB_COALESCE_EN.
//   clk, rstn   core clock, async active-low reset
//   bus         rrv64_l1d_stb_q_if.slave (st_req_*, dc_req_*, ld_fwd_*)
//   stb_empty   no valid entries
//   stb_full    cnt == DEPTH
//   stb_cnt     occupancy
module rrv64_l1d_stb_q
  import rrv64_l1d_stb_q_pkg::*;
#(
  parameter int DEPTH   = RRV64_L1D_STB_D,
  parameter int PADDR_W = RRV64_PHY_ADDR_WIDTH,
  parameter int DATA_W  = RRV64_L1D_STB_DATA_W
)(
  input  logic                     clk,
  input  logic                     rstn,
  rrv64_l1d_stb_q_if.slave         bus,
  output logic                     stb_empty,
  output logic                     stb_full,
  output logic [$clog2(DEPTH):0]   stb_cnt
);
  localparam int MASK_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(MASK_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int AW     = PADDR_W - OFF_W;
  localparam int CNT_W  = IDX_W + 1;

  logic [DEPTH-1:0]               r_vld;
  logic [DEPTH-1:0][AW-1:0]       r_addr;
  logic [DEPTH-1:0][DATA_W-1:0]   r_data;
  logic [DEPTH-1:0][MASK_W-1:0]   r_mask;
  logic [IDX_W-1:0]               r_head;
  logic [IDX_W-1:0]               r_tail;
  logic [CNT_W-1:0]               r_cnt;

  logic [AW-1:0]    w_st_dw;
  logic [IDX_W-1:0] w_yng;
  logic             w_full, w_empty;
  logic             w_merge_ok, w_push, w_alloc, w_merge, w_pop;
  logic             w_unused_lo;

  // Sub-lane address bits only select bytes, which the mask already does.
  assign w_unused_lo = ^{bus.st_req_addr[OFF_W-1:0], bus.ld_fwd_addr[OFF_W-1:0]};

  assign w_st_dw = bus.st_req_addr[PADDR_W-1:OFF_W];
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_yng   = r_tail - IDX_W'(1);

`ifdef RRV64_L1D_STB_COALESCE_EN
  // Merge only into the youngest entry and never into the head, which may be
  // mid-handshake with the cache; this keeps store order intact.
  assign w_merge_ok = ((r_cnt >= CNT_W'(2)) ||
                       ((r_cnt == CNT_W'(1)) && !bus.dc_req_valid)) &&
                      r_vld[w_yng] && (w_yng != r_head) &&
                      (r_addr[w_yng] == w_st_dw);
  assign bus.st_req_ready = !w_full || w_merge_ok;
`else
  assign w_merge_ok       = 1'b0;
  // A pop in the same cycle does not free a slot for the push.
  assign bus.st_req_ready = !w_full;
`endif

  assign w_push  = bus.st_req_valid && bus.st_req_ready;
  assign w_merge = w_push && w_merge_ok;
  assign w_alloc = w_push && !w_merge_ok;
  assign w_pop   = bus.dc_req_valid && bus.dc_req_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld  <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_alloc) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + IDX_W'(1);
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + IDX_W'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload is qualified by r_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= w_st_dw;
      r_data[r_tail] <= bus.st_req_data;
      r_mask[r_tail] <= bus.st_req_mask;
    end
    if (w_merge) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (bus.st_req_mask[b]) r_data[w_yng][b*8 +: 8] <= bus.st_req_data[b*8 +: 8];
      end
      r_mask[w_yng] <= r_mask[w_yng] | bus.st_req_mask;
    end
  end

  assign bus.dc_req_valid = !w_empty;
  assign bus.dc_req_addr  = {r_addr[r_head], {OFF_W{1'b0}}};
  assign bus.dc_req_data  = r_data[r_head];
  assign bus.dc_req_mask  = r_mask[r_head];

  assign stb_empty = w_empty;
  assign stb_full  = w_full;
  assign stb_cnt   = r_cnt;

  rrv64_l1d_stb_fwd_sel #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_fwd_sel (
    .i_vld       (r_vld),
    .i_addr      (r_addr),
    .i_data      (r_data),
    .i_mask      (r_mask),
    .i_head      (r_head),
    .i_lkup_addr (bus.ld_fwd_addr[PADDR_W-1:OFF_W]),
    .o_data      (bus.ld_fwd_data),
    .o_mask      (bus.ld_fwd_mask)
  );
endmodule
